// File: rtl/alu_share_arbiter.sv
// Purpose : shares one external combinational ALU between two requesters using round-robin arbitration.
// Latency : a request handshaken at edge T has its response valid after edge T+1, and at most one op issues every 2 cycles.
// Backpres: a requester whose response is still unconsumed is never granted; responses are held until rsp*_ready.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   reqN_valid/ready/a/b/op            request channel of requester N (N = 0, 1)
//   rspN_valid/ready/data/cout         response channel of requester N
//   alu_a/alu_b/alu_op -> alu_res/cout shared ALU interface (ALU is combinational, outside this block)
//   busy                               high while the ALU is executing (EXEC)
//   grant_id                           requester owning the current/last operation
module alu_share_arbiter #(
    parameter int W   = 4,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [W-1:0]   rsp0_data,
    output logic           rsp0_cout,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [W-1:0]   rsp1_data,
    output logic           rsp1_cout,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_res,
    input  logic           alu_cout,
    output logic           busy,
    output logic           grant_id
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t         r_state;
    logic           r_last;
    logic           r_grant_id;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [OPW-1:0] r_alu_op;
    logic           r_rsp0_valid;
    logic [W-1:0]   r_rsp0_data;
    logic           r_rsp0_cout;
    logic           r_rsp1_valid;
    logic [W-1:0]   r_rsp1_data;
    logic           r_rsp1_cout;

    logic w_elig0;
    logic w_elig1;
    logic w_gnt_vld;
    logic w_gnt_sel;

    // Eligibility only looks at the registered response valid, so there is
    // no combinational path from rsp*_ready to req*_ready.
    assign w_elig0   = req0_valid & ~r_rsp0_valid;
    assign w_elig1   = req1_valid & ~r_rsp1_valid;
    assign w_gnt_vld = (r_state == S_IDLE) & (w_elig0 | w_elig1);
    // Requester 1 wins when it is the only one eligible, or on a tie when
    // requester 0 had the last operation.
    assign w_gnt_sel = w_elig1 & (~w_elig0 | ~r_last);

    assign req0_ready = w_gnt_vld & ~w_gnt_sel;
    assign req1_ready = w_gnt_vld &  w_gnt_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last       <= 1'b1;
            r_grant_id   <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp0_cout  <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= '0;
            r_rsp1_cout  <= 1'b0;
        end else begin
            // Consumption first; a completing operation below may only set
            // the valid of a requester whose response was already empty.
            if (r_rsp0_valid && rsp0_ready) begin
                r_rsp0_valid <= 1'b0;
            end
            if (r_rsp1_valid && rsp1_ready) begin
                r_rsp1_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_alu_a    <= w_gnt_sel ? req1_a  : req0_a;
                        r_alu_b    <= w_gnt_sel ? req1_b  : req0_b;
                        r_alu_op   <= w_gnt_sel ? req1_op : req0_op;
                        r_grant_id <= w_gnt_sel;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_grant_id) begin
                        r_rsp1_valid <= 1'b1;
                        r_rsp1_data  <= alu_res;
                        r_rsp1_cout  <= alu_cout;
                    end else begin
                        r_rsp0_valid <= 1'b1;
                        r_rsp0_data  <= alu_res;
                        r_rsp0_cout  <= alu_cout;
                    end
                    r_last  <= r_grant_id;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ALU operands stay at their last latched values outside EXEC.
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign busy       = (r_state == S_EXEC);
    assign grant_id   = r_grant_id;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp0_cout  = r_rsp0_cout;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_data  = r_rsp1_data;
    assign rsp1_cout  = r_rsp1_cout;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose : directed and randomized bench for alu_share_arbiter against a transaction-level reference model.
// Latency : inputs are driven 1 time unit after the rising edge, and outputs are checked on the falling edge.
// Backpres: response readiness is randomized, and a simple external ALU model drives alu_res/alu_cout.
module tb_alu_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [3:0] rsp0_data, rsp1_data;
    logic       rsp0_cout, rsp1_cout;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_res;
    logic       alu_cout;
    logic       busy;
    logic       grant_id;

    int total = 0;
    int bad   = 0;

    alu_share_arbiter #(.W(4), .OPW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_cout  (rsp0_cout),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_cout  (rsp1_cout),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_res    (alu_res),
        .alu_cout   (alu_cout),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: 010 add, 001 negate A, 000 and, 011 or, others xor.
    function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [4:0] r;
        case (op)
            3'b010:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {1'b0, 4'(~a + 4'd1)};
            3'b000:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    assign {alu_cout, alu_res} = ref_alu(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an operation is either in flight or not; each
    // requester has a response slot that is either full or empty.
    // ------------------------------------------------------------------
    bit         m_on = 1'b0;
    bit         m_busy;
    bit         m_g;
    bit         m_last;
    bit   [1:0] m_rv;
    logic [3:0] m_rd [2];
    logic       m_rc [2];
    logic [3:0] m_a, m_b;
    logic [2:0] m_op;

    // Returns {grant_valid, grant_id} from the round-robin rule.
    function automatic bit [1:0] pick(input bit v0, input bit v1, input bit [1:0] rv, input bit last);
        bit e0, e1, g;
        e0 = v0 && !rv[0];
        e1 = v1 && !rv[1];
        if (e0 && e1) g = !last;
        else          g = e1;
        return {e0 || e1, g};
    endfunction

    always @(posedge clk) begin
        bit [1:0] gg;
        if (!rst_n) begin
            m_on   = 1'b1;
            m_busy = 1'b0;
            m_g    = 1'b0;
            m_last = 1'b1;
            m_rv   = 2'b00;
            m_rd[0] = 4'd0; m_rd[1] = 4'd0;
            m_rc[0] = 1'b0; m_rc[1] = 1'b0;
            m_a = 4'd0; m_b = 4'd0; m_op = 3'd0;
        end else if (m_on) begin
            gg = pick(req0_valid, req1_valid, m_rv, m_last);
            if (m_rv[0] && rsp0_ready) m_rv[0] = 1'b0;
            if (m_rv[1] && rsp1_ready) m_rv[1] = 1'b0;
            if (m_busy) begin
                {m_rc[m_g], m_rd[m_g]} = ref_alu(m_a, m_b, m_op);
                m_rv[m_g] = 1'b1;
                m_last    = m_g;
                m_busy    = 1'b0;
            end else if (gg[1]) begin
                m_g    = gg[0];
                m_a    = m_g ? req1_a  : req0_a;
                m_b    = m_g ? req1_b  : req0_b;
                m_op   = m_g ? req1_op : req0_op;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        bit [1:0] gg;
        bit       e_r0, e_r1;
        if (m_on && rst_n) begin
            gg   = pick(req0_valid, req1_valid, m_rv, m_last);
            e_r0 = !m_busy && gg[1] && !gg[0];
            e_r1 = !m_busy && gg[1] &&  gg[0];
            check("m_req0_ready", req0_ready, e_r0);
            check("m_req1_ready", req1_ready, e_r1);
            check("m_busy",       busy,       m_busy);
            check("m_grant_id",   grant_id,   m_g);
            check("m_alu_a",      alu_a,      m_a);
            check("m_alu_b",      alu_b,      m_b);
            check("m_alu_op",     alu_op,     m_op);
            check("m_rsp0_valid", rsp0_valid, m_rv[0]);
            check("m_rsp1_valid", rsp1_valid, m_rv[1]);
            check("m_rsp0_data",  rsp0_data,  m_rd[0]);
            check("m_rsp1_data",  rsp1_data,  m_rd[1]);
            check("m_rsp0_cout",  rsp0_cout,  m_rc[0]);
            check("m_rsp1_cout",  rsp1_cout,  m_rc[1]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    int n0, n1, ng;
    bit prev_g;

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req0_op = 3'd0;
        req1_a = 4'd0; req1_b = 4'd0; req1_op = 3'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state
        cyc(); cyc();
        at_neg();
        check("rst_busy",  busy, 1'b0);
        check("rst_gid",   grant_id, 1'b0);
        check("rst_rsp0v", rsp0_valid, 1'b0);
        check("rst_rsp1v", rsp1_valid, 1'b0);
        check("rst_alu_a", alu_a, 4'd0);
        check("rst_alu_op", alu_op, 3'd0);

        // Single request from requester 0: 3 + 5
        cyc();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5; req0_op = 3'b010;
        at_neg();
        check("t1_rdy0", req0_ready, 1'b1);
        check("t1_rdy1", req1_ready, 1'b0);
        cyc();
        req0_valid = 1'b0;
        at_neg();
        check("t1_busy",  busy, 1'b1);
        check("t1_alu_a", alu_a, 4'd3);
        check("t1_alu_b", alu_b, 4'd5);
        check("t1_alu_op", alu_op, 3'b010);
        cyc();
        at_neg();
        check("t1_rsp0v", rsp0_valid, 1'b1);
        check("t1_data",  rsp0_data, 4'd8);
        check("t1_cout",  rsp0_cout, 1'b0);
        check("t1_rsp1v", rsp1_valid, 1'b0);
        cyc();
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;

        // Both requesters always valid, responses always consumed
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd2; req0_op = 3'b011;
        req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd6; req1_op = 3'b100;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        ng = 0;
        for (int i = 0; i < 8; i++) begin
            at_neg();
            if (req0_ready || req1_ready) begin
                if (ng > 0) check("t2_alternate", req1_ready, !prev_g);
                prev_g = req1_ready;
                ng++;
            end
            cyc();
        end
        check("t2_grant_cnt", ng, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(); cyc(); cyc();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Requester 1 overflow add held unconsumed
        req1_valid = 1'b1; req1_a = 4'hF; req1_b = 4'h1; req1_op = 3'b010;
        n1 = 0;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            if (req1_ready) n1++;
            cyc();
        end
        check("t3_one_grant", n1, 1);
        at_neg();
        check("t3_rsp1v", rsp1_valid, 1'b1);
        check("t3_data",  rsp1_data, 4'h0);
        check("t3_cout",  rsp1_cout, 1'b1);
        cyc();
        rsp1_ready = 1'b1;
        cyc();
        rsp1_ready = 1'b0;
        at_neg();
        check("t3_regrant", req1_ready, 1'b1);
        cyc();
        req1_valid = 1'b0;
        cyc(); cyc();
        rsp1_ready = 1'b1;
        cyc();
        rsp1_ready = 1'b0;

        // Requester 0 blocked by its own unconsumed response
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_op = 3'b000;
        at_neg();
        check("t4_rdy0_first", req0_ready, 1'b1);
        cyc();
        req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd4; req1_op = 3'b010;
        rsp1_ready = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            if (req0_ready) n0++;
            if (req1_ready) n1++;
            cyc();
        end
        check("t4_req0_blocked", n0, 0);
        check("t4_req1_grants", n1, 3);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        cyc(); cyc(); cyc();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset in the middle of EXEC
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6 && !busy; i++) cyc();
        check("t5_in_exec", busy, 1'b1);
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc();
        at_neg();
        check("t5_busy",  busy, 1'b0);
        check("t5_rsp0v", rsp0_valid, 1'b0);
        check("t5_rsp1v", rsp1_valid, 1'b0);
        check("t5_alu_a", alu_a, 4'd0);
        check("t5_alu_b", alu_b, 4'd0);
        check("t5_gid",   grant_id, 1'b0);
        cyc();
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        at_neg();
        check("t5_tie_rdy0", req0_ready, 1'b1);
        check("t5_tie_rdy1", req1_ready, 1'b0);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(); cyc();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        cyc(); cyc();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Negate opcode passed through verbatim
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd0; req0_op = 3'b001;
        cyc();
        req0_valid = 1'b0;
        at_neg();
        check("t6_alu_op", alu_op, 3'b001);
        cyc();
        at_neg();
        check("t6_data", rsp0_data, 4'hB);
        cyc();
        rsp0_ready = 1'b1;
        cyc();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a  = 4'($urandom); req0_b = 4'($urandom); req0_op = 3'($urandom);
            req1_a  = 4'($urandom); req1_b = 4'($urandom); req1_op = 3'($urandom);
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
